// File: rtl/bcd_rtc_count.sv
// BCD real-time clock: seconds prescaler, 24h/12h hour sequencing, validated
// time load and a one-shot HH:MM:00 alarm. All outputs are registered.
module bcd_rtc_count #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter bit MODE_12H      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] ld_ms_hr,
    input  logic [3:0] ld_ls_hr,
    input  logic [3:0] ld_ms_min,
    input  logic [3:0] ld_ls_min,
    input  logic [3:0] ld_ms_sec,
    input  logic [3:0] ld_ls_sec,
    input  logic       ld_pm,
    input  logic       al_en,
    input  logic [3:0] al_ms_hr,
    input  logic [3:0] al_ls_hr,
    input  logic [3:0] al_ms_min,
    input  logic [3:0] al_ls_min,
    input  logic       al_pm,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic [3:0] ms_sec,
    output logic [3:0] ls_sec,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_wrap,
    output logic       alarm,
    output logic       load_err
);

    localparam int             PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]  PS_TC     = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     RST_MS_HR = MODE_12H ? 4'd1 : 4'd0;
    localparam logic [3:0]     RST_LS_HR = MODE_12H ? 4'd2 : 4'd0;

    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          w_ld_ok;
    logic          w_digits_ok;
    logic          w_hr_ok;
    logic          w_c0, w_c1, w_c2, w_c3;
    logic [3:0]    w_n_ms_hr, w_n_ls_hr, w_n_ms_min, w_n_ls_min, w_n_ms_sec, w_n_ls_sec;
    logic          w_n_pm;
    logic          w_n_wrap;
    logic          w_n_alarm;

    assign w_tick = en && (r_presc == PS_TC);

    always_comb begin
        w_digits_ok = (ld_ms_hr <= 4'd9) && (ld_ls_hr <= 4'd9) &&
                      (ld_ms_min <= 4'd5) && (ld_ls_min <= 4'd9) &&
                      (ld_ms_sec <= 4'd5) && (ld_ls_sec <= 4'd9);
        if (MODE_12H)
            w_hr_ok = ((ld_ms_hr == 4'd0) && (ld_ls_hr != 4'd0) && (ld_ls_hr <= 4'd9)) ||
                      ((ld_ms_hr == 4'd1) && (ld_ls_hr <= 4'd2));
        else
            w_hr_ok = (ld_ms_hr < 4'd2) || ((ld_ms_hr == 4'd2) && (ld_ls_hr <= 4'd3));
        w_ld_ok = w_digits_ok && w_hr_ok;
    end

    assign w_c0 = (ls_sec == 4'd9);
    assign w_c1 = w_c0 && (ms_sec == 4'd5);
    assign w_c2 = w_c1 && (ls_min == 4'd9);
    assign w_c3 = w_c2 && (ms_min == 4'd5);

    always_comb begin
        w_n_ls_sec = w_c0 ? 4'd0 : ls_sec + 4'd1;
        w_n_ms_sec = w_c1 ? 4'd0 : (w_c0 ? ms_sec + 4'd1 : ms_sec);
        w_n_ls_min = w_c2 ? 4'd0 : (w_c1 ? ls_min + 4'd1 : ls_min);
        w_n_ms_min = w_c3 ? 4'd0 : (w_c2 ? ms_min + 4'd1 : ms_min);
        w_n_ms_hr  = ms_hr;
        w_n_ls_hr  = ls_hr;
        w_n_pm     = pm;
        w_n_wrap   = 1'b0;
        if (w_c3) begin
            if (MODE_12H) begin
                // 12 -> 01 keeps the meridiem; 11 -> 12 flips it, PM->AM is midnight
                if (ms_hr == 4'd1 && ls_hr == 4'd2) begin
                    w_n_ms_hr = 4'd0;
                    w_n_ls_hr = 4'd1;
                end else if (ms_hr == 4'd1 && ls_hr == 4'd1) begin
                    w_n_ls_hr = 4'd2;
                    w_n_pm    = ~pm;
                    w_n_wrap  = pm;
                end else if (ls_hr == 4'd9) begin
                    w_n_ms_hr = ms_hr + 4'd1;
                    w_n_ls_hr = 4'd0;
                end else begin
                    w_n_ls_hr = ls_hr + 4'd1;
                end
            end else begin
                if (ms_hr == 4'd2 && ls_hr == 4'd3) begin
                    w_n_ms_hr = 4'd0;
                    w_n_ls_hr = 4'd0;
                    w_n_wrap  = 1'b1;
                end else if (ls_hr == 4'd9) begin
                    w_n_ms_hr = ms_hr + 4'd1;
                    w_n_ls_hr = 4'd0;
                end else begin
                    w_n_ls_hr = ls_hr + 4'd1;
                end
            end
        end
        w_n_alarm = al_en &&
                    (w_n_ms_hr == al_ms_hr) && (w_n_ls_hr == al_ls_hr) &&
                    (w_n_ms_min == al_ms_min) && (w_n_ls_min == al_ls_min) &&
                    (w_n_ms_sec == 4'd0) && (w_n_ls_sec == 4'd0) &&
                    (!MODE_12H || (w_n_pm == al_pm));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= '0;
            ms_hr     <= RST_MS_HR;
            ls_hr     <= RST_LS_HR;
            ms_min    <= 4'd0;
            ls_min    <= 4'd0;
            ms_sec    <= 4'd0;
            ls_sec    <= 4'd0;
            pm        <= 1'b0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            alarm     <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            alarm     <= 1'b0;
            load_err  <= 1'b0;
            if (load && w_ld_ok) begin
                // an accepted load swallows any coincident tick
                r_presc <= '0;
                ms_hr   <= ld_ms_hr;
                ls_hr   <= ld_ls_hr;
                ms_min  <= ld_ms_min;
                ls_min  <= ld_ls_min;
                ms_sec  <= ld_ms_sec;
                ls_sec  <= ld_ls_sec;
                pm      <= MODE_12H && ld_pm;
            end else begin
                load_err <= load;
                if (w_tick) begin
                    r_presc   <= '0;
                    ms_hr     <= w_n_ms_hr;
                    ls_hr     <= w_n_ls_hr;
                    ms_min    <= w_n_ms_min;
                    ls_min    <= w_n_ls_min;
                    ms_sec    <= w_n_ms_sec;
                    ls_sec    <= w_n_ls_sec;
                    pm        <= w_n_pm;
                    sec_pulse <= 1'b1;
                    day_wrap  <= w_n_wrap;
                    alarm     <= w_n_alarm;
                end else if (en) begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_rtc_count.sv
// Directed bench: a 24h instance and a 12h instance (4 ticks/second) share all
// inputs; each task checks the instance relevant to its scenario.
module tb_bcd_rtc_count;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       load = 1'b0;
    logic [3:0] ld_ms_hr = '0, ld_ls_hr = '0, ld_ms_min = '0, ld_ls_min = '0, ld_ms_sec = '0, ld_ls_sec = '0;
    logic       ld_pm = 1'b0;
    logic       al_en = 1'b0;
    logic [3:0] al_ms_hr = '0, al_ls_hr = '0, al_ms_min = '0, al_ls_min = '0;
    logic       al_pm = 1'b0;

    logic [3:0] a_ms_hr, a_ls_hr, a_ms_min, a_ls_min, a_ms_sec, a_ls_sec;
    logic       a_pm, a_sec, a_wrap, a_alarm, a_err;
    logic [3:0] b_ms_hr, b_ls_hr, b_ms_min, b_ls_min, b_ms_sec, b_ls_sec;
    logic       b_pm, b_sec, b_wrap, b_alarm, b_err;
    logic [23:0] t24, t12;

    int errors = 0;
    int checks = 0;

    assign t24 = {a_ms_hr, a_ls_hr, a_ms_min, a_ls_min, a_ms_sec, a_ls_sec};
    assign t12 = {b_ms_hr, b_ls_hr, b_ms_min, b_ls_min, b_ms_sec, b_ls_sec};

    always #5 clk = ~clk;

    bcd_rtc_count #(.TICKS_PER_SEC(4), .MODE_12H(1'b0)) dut24 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .ld_ms_hr(ld_ms_hr), .ld_ls_hr(ld_ls_hr), .ld_ms_min(ld_ms_min),
        .ld_ls_min(ld_ls_min), .ld_ms_sec(ld_ms_sec), .ld_ls_sec(ld_ls_sec), .ld_pm(ld_pm),
        .al_en(al_en), .al_ms_hr(al_ms_hr), .al_ls_hr(al_ls_hr),
        .al_ms_min(al_ms_min), .al_ls_min(al_ls_min), .al_pm(al_pm),
        .ms_hr(a_ms_hr), .ls_hr(a_ls_hr), .ms_min(a_ms_min), .ls_min(a_ls_min),
        .ms_sec(a_ms_sec), .ls_sec(a_ls_sec), .pm(a_pm), .sec_pulse(a_sec),
        .day_wrap(a_wrap), .alarm(a_alarm), .load_err(a_err)
    );

    bcd_rtc_count #(.TICKS_PER_SEC(4), .MODE_12H(1'b1)) dut12 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .ld_ms_hr(ld_ms_hr), .ld_ls_hr(ld_ls_hr), .ld_ms_min(ld_ms_min),
        .ld_ls_min(ld_ls_min), .ld_ms_sec(ld_ms_sec), .ld_ls_sec(ld_ls_sec), .ld_pm(ld_pm),
        .al_en(al_en), .al_ms_hr(al_ms_hr), .al_ls_hr(al_ls_hr),
        .al_ms_min(al_ms_min), .al_ls_min(al_ls_min), .al_pm(al_pm),
        .ms_hr(b_ms_hr), .ls_hr(b_ls_hr), .ms_min(b_ms_min), .ls_min(b_ls_min),
        .ms_sec(b_ms_sec), .ls_sec(b_ls_sec), .pm(b_pm), .sec_pulse(b_sec),
        .day_wrap(b_wrap), .alarm(b_alarm), .load_err(b_err)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [23:0] t, input logic p);
        {ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min, ld_ms_sec, ld_ls_sec} = t;
        ld_pm = p;
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        en  = 1'b1;
        step(2);
        checks++; if (t24 !== 24'h000000) begin errors++; $display("FAIL reset_t24 got=%h exp=000000", t24); end
        checks++; if (t12 !== 24'h120000 || b_pm !== 1'b0) begin errors++; $display("FAIL reset_t12 got=%h pm=%b exp=120000 pm=0", t12, b_pm); end
        checks++; if ({a_sec, a_wrap, a_alarm, a_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {a_sec, a_wrap, a_alarm, a_err}); end
    endtask

    task automatic test_prescaler;
        rst = 1'b1;
        step(3);
        checks++; if (a_sec !== 1'b0 || t24 !== 24'h000000) begin errors++; $display("FAIL presc_early got=%h pulse=%b exp=000000 pulse=0", t24, a_sec); end
        step(1);
        checks++; if (a_sec !== 1'b1 || t24 !== 24'h000001 || a_wrap !== 1'b0) begin errors++; $display("FAIL presc_first got=%h pulse=%b wrap=%b exp=000001 1 0", t24, a_sec, a_wrap); end
        step(3);
        checks++; if (a_sec !== 1'b0) begin errors++; $display("FAIL presc_gap got=%b exp=0", a_sec); end
        step(1);
        checks++; if (a_sec !== 1'b1 || t24 !== 24'h000002) begin errors++; $display("FAIL presc_second got=%h pulse=%b exp=000002 1", t24, a_sec); end
        en = 1'b0;
        step(6);
        checks++; if (t24 !== 24'h000002 || a_sec !== 1'b0) begin errors++; $display("FAIL en_hold got=%h pulse=%b exp=000002 0", t24, a_sec); end
        en = 1'b1;
    endtask

    task automatic test_rollover_24h;
        logic [23:0] ld_tab [3] = '{24'h095959, 24'h195959, 24'h235958};
        logic [23:0] ex_tab [3] = '{24'h100000, 24'h200000, 24'h235959};
        for (int k = 0; k < 3; k++) begin
            do_load(ld_tab[k], 1'b0);
            step(4);
            checks++; if (t24 !== ex_tab[k] || a_wrap !== 1'b0) begin errors++; $display("FAIL carry24_%0d got=%h wrap=%b exp=%h 0", k, t24, a_wrap, ex_tab[k]); end
        end
        step(4);
        checks++; if (t24 !== 24'h000000 || a_wrap !== 1'b1) begin errors++; $display("FAIL daywrap24 got=%h wrap=%b exp=000000 1", t24, a_wrap); end
        step(1);
        checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL daywrap24_once got=%b exp=0", a_wrap); end
    endtask

    task automatic test_rollover_12h;
        do_load(24'h115959, 1'b0);
        step(4);
        checks++; if (t12 !== 24'h120000 || b_pm !== 1'b1 || b_wrap !== 1'b0) begin errors++; $display("FAIL am_to_pm got=%h pm=%b wrap=%b exp=120000 1 0", t12, b_pm, b_wrap); end
        checks++; if (a_pm !== 1'b0) begin errors++; $display("FAIL pm24_zero got=%b exp=0", a_pm); end
        do_load(24'h125959, 1'b1);
        step(4);
        checks++; if (t12 !== 24'h010000 || b_pm !== 1'b1 || b_wrap !== 1'b0) begin errors++; $display("FAIL twelve_to_one got=%h pm=%b wrap=%b exp=010000 1 0", t12, b_pm, b_wrap); end
        do_load(24'h115959, 1'b1);
        step(4);
        checks++; if (t12 !== 24'h120000 || b_pm !== 1'b0 || b_wrap !== 1'b1) begin errors++; $display("FAIL midnight12 got=%h pm=%b wrap=%b exp=120000 0 1", t12, b_pm, b_wrap); end
    endtask

    task automatic test_invalid_load;
        do_load(24'h050607, 1'b0);
        do_load(24'h240000, 1'b0);
        checks++; if (a_err !== 1'b1 || t24 !== 24'h050607) begin errors++; $display("FAIL bad_hr24 got=%h err=%b exp=050607 1", t24, a_err); end
        step(1);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_once got=%b exp=0", a_err); end
        do_load(24'h050607, 1'b0);
        do_load(24'h003000, 1'b0);
        checks++; if (b_err !== 1'b1 || t12 !== 24'h050607) begin errors++; $display("FAIL bad_hr12 got=%h err=%b exp=050607 1", t12, b_err); end
        checks++; if (a_err !== 1'b0 || t24 !== 24'h003000) begin errors++; $display("FAIL ok_hr24 got=%h err=%b exp=003000 0", t24, a_err); end
        do_load(24'h050607, 1'b0);
        do_load(24'h126000, 1'b0);
        checks++; if (a_err !== 1'b1 || b_err !== 1'b1 || t24 !== 24'h050607 || t12 !== 24'h050607) begin errors++; $display("FAIL bad_min got=%h/%h err=%b%b exp=050607 11", t24, t12, a_err, b_err); end
        do_load(24'h05060A, 1'b0);
        checks++; if (a_err !== 1'b1 || t24 !== 24'h050607) begin errors++; $display("FAIL bad_digit got=%h err=%b exp=050607 1", t24, a_err); end
    endtask

    task automatic test_load_vs_tick;
        do_load(24'h010203, 1'b0);
        step(3);
        do_load(24'h040506, 1'b0);
        checks++; if (t24 !== 24'h040506 || a_sec !== 1'b0) begin errors++; $display("FAIL load_wins got=%h pulse=%b exp=040506 0", t24, a_sec); end
        step(3);
        checks++; if (t24 !== 24'h040506 || a_sec !== 1'b0) begin errors++; $display("FAIL presc_restart got=%h pulse=%b exp=040506 0", t24, a_sec); end
        step(1);
        checks++; if (t24 !== 24'h040507 || a_sec !== 1'b1) begin errors++; $display("FAIL after_load_tick got=%h pulse=%b exp=040507 1", t24, a_sec); end
        do_load(24'h010203, 1'b0);
        step(3);
        do_load(24'h250000, 1'b0);
        checks++; if (t24 !== 24'h010204 || a_sec !== 1'b1 || a_err !== 1'b1) begin errors++; $display("FAIL reject_tick got=%h pulse=%b err=%b exp=010204 1 1", t24, a_sec, a_err); end
    endtask

    task automatic test_alarm;
        {al_ms_hr, al_ls_hr, al_ms_min, al_ls_min} = 16'h0730;
        al_pm = 1'b0;
        al_en = 1'b1;
        do_load(24'h072959, 1'b0);
        step(3);
        checks++; if (a_alarm !== 1'b0) begin errors++; $display("FAIL alarm_early got=%b exp=0", a_alarm); end
        step(1);
        checks++; if (a_alarm !== 1'b1 || b_alarm !== 1'b1 || t24 !== 24'h073000) begin errors++; $display("FAIL alarm_hit got=%h al=%b%b exp=073000 11", t24, a_alarm, b_alarm); end
        step(1);
        checks++; if (a_alarm !== 1'b0) begin errors++; $display("FAIL alarm_once got=%b exp=0", a_alarm); end
        do_load(24'h073000, 1'b0);
        checks++; if (a_alarm !== 1'b0 || t24 !== 24'h073000) begin errors++; $display("FAIL alarm_load got=%h al=%b exp=073000 0", t24, a_alarm); end
        step(4);
        checks++; if (a_alarm !== 1'b0 || t24 !== 24'h073001) begin errors++; $display("FAIL alarm_load_next got=%h al=%b exp=073001 0", t24, a_alarm); end
        do_load(24'h072959, 1'b1);
        step(4);
        checks++; if (a_alarm !== 1'b1 || b_alarm !== 1'b0) begin errors++; $display("FAIL alarm_pm got=%b%b exp=10", a_alarm, b_alarm); end
        al_en = 1'b0;
        do_load(24'h072959, 1'b0);
        step(4);
        checks++; if (a_alarm !== 1'b0 || b_alarm !== 1'b0 || t24 !== 24'h073000) begin errors++; $display("FAIL alarm_off got=%h al=%b%b exp=073000 00", t24, a_alarm, b_alarm); end
    endtask

    task automatic test_async_reset;
        do_load(24'h051234, 1'b1);
        step(2);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (t24 !== 24'h000000) begin errors++; $display("FAIL async_t24 got=%h exp=000000", t24); end
        checks++; if (t12 !== 24'h120000 || b_pm !== 1'b0) begin errors++; $display("FAIL async_t12 got=%h pm=%b exp=120000 0", t12, b_pm); end
        step(2);
        rst = 1'b1;
        step(4);
        checks++; if (t24 !== 24'h000001 || a_sec !== 1'b1) begin errors++; $display("FAIL post_reset got=%h pulse=%b exp=000001 1", t24, a_sec); end
    endtask

    initial begin
        test_reset;
        test_prescaler;
        test_rollover_24h;
        test_rollover_12h;
        test_invalid_load;
        test_load_vs_tick;
        test_alarm;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
